dispatch_arbiter: RTL and testbench
===================================

// Module: dispatch_arbiter
// PURPOSE
//   Round-robin arbiter that merges NUM_REQ independent host command streams into the
//   single src valid/ready stream consumed by network_source.
//   - Guarantees atomicity of a spike transaction: SPK/SPK_PRDC words followed by the
//     terminating RUN or CLR.
//   - A requester that starts a transaction keeps the grant until it finishes or times out.
//   - Sits between the host I/O front-ends and network_source. Output is registered.
// PARAMETERS
//   NUM_REQ       2             number of requesters (>=1)
//   SRC_W         `SRC_WIDTH    command word width; opcode in [SRC_W-1 -: OPC_WIDTH]
//   LOCK_TIMEOUT  1024          idle cycles while locked before forced release; 0 = never
// PORTS
//   clk        in   1                   clock
//   arstn      in   1                   async active-low reset
//   req_valid  in   NUM_REQ             per-requester word valid
//   req_ready  out  NUM_REQ             per-requester word accepted (combinational)
//   req_data   in   NUM_REQ x SRC_W     per-requester command words, unpacked [0:NUM_REQ-1]
//   src_valid  out  1                   to network_source src_valid
//   src_ready  in   1                   from network_source src_ready
//   src        out  SRC_W               to network_source src
//   owner      out  $clog2(NUM_REQ)|1   index of last/current granted requester
//   locked     out  1                   transaction lock held by owner
//   lock_abort out  1                   1-cycle pulse: lock released by timeout
// BEHAVIOUR
//   Reset: clock clk; reset arstn, asynchronous, active-low.
//     - All outputs 0, state IDLE, rr_ptr 0, timeout counter 0.
//     - Reset mid-transaction drops the held word and the lock with no flush.
//   Output stage: one register.
//     - load_en = !src_valid || src_ready.
//     - On accept: src <= req_data[g], src_valid <= 1.
//     - Else if src_ready: src_valid <= 0.
//     - Latency: requester handshake to src_valid is 1 cycle.
//     - src is held stable while src_valid && !src_ready.
//     - Full throughput: 1 word/cycle with src_ready held high.
//   Grant g (combinational):
//     - IDLE: first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - LOCKED: g = owner only.
//     - req_ready[i] = load_en && (i == g) && req_valid[g].
//     - At most one req_ready is high per cycle.
//   FSM, evaluated on an accepted word with opc = req_data[g] opcode:
//     - IDLE, opc SPK or SPK_PRDC -> LOCKED; owner <= g.
//     - IDLE, opc RUN/CLR/NOP/invalid (>= NUM_OPS) -> stay IDLE; owner <= g;
//       rr_ptr <= (g+1) mod NUM_REQ.
//     - LOCKED, opc RUN or CLR -> IDLE; rr_ptr <= (owner+1) mod NUM_REQ.
//     - LOCKED, any other opc -> stay LOCKED.
//     - Invalid opcodes are forwarded unchanged and never alter the lock.
//   Timeout, LOCKED only, LOCK_TIMEOUT > 0:
//     - Counter is cleared on every accepted word and increments while !req_valid[owner].
//     - On reaching LOCK_TIMEOUT: -> IDLE, rr_ptr <= owner+1, lock_abort pulses 1 cycle.
//     - Counter saturates; width is $clog2(LOCK_TIMEOUT+1).
//     - req_valid[owner] held high while stalled by src_ready=0 is not idle; no timeout.
//   Simultaneous events:
//     - Timeout and owner word acceptance in the same cycle: the acceptance wins.
//     - A word accepted with src_valid && src_ready in the same cycle overwrites the
//       stage with no bubble.
//   Wrap-around: rr_ptr == NUM_REQ-1 advances to 0.
//   NUM_REQ == 1: degenerates to a registered pass-through; lock and timeout still tracked.
// STRUCTURE
//   - Import source_config (opcode_t, OPC_WIDTH, NUM_OPS).
//   - Add arb_state_t {ARB_IDLE, ARB_LOCKED} to source_config.
//   - Sub-module rr_pick: combinational round-robin first-one search (req mask, ptr -> idx,
//     any). It is reused by later multi-host blocks.
//   - Output stage, FSM and timeout counter are inline always_ff blocks.
// TESTING
//   1. NUM_REQ=2; both send NOP continuously, src_ready=1 -> src alternates r0,r1,r0...;
//      1-cycle latency.
//   2. r0 sends SPK,SPK,RUN while r1 holds RUN valid -> src = r0 SPK,SPK,RUN, then r1 RUN;
//      locked high from the 1st SPK through the RUN.
//   3. src_ready=0 for 5 cycles while r1 is locked -> src is stable, no req_ready,
//      lock_abort=0.
//   4. LOCK_TIMEOUT=8; r0 sends SPK, then drops valid -> lock_abort pulses 8 cycles later;
//      r1's pending word is granted next.
//   5. r1 sends SPK_PRDC then CLR -> lock released on CLR; rr_ptr=0; invalid opcode 7
//      forwarded without locking.
//   6. Assert arstn low while locked with src_valid=1 -> all outputs 0 immediately; IDLE
//      after release.

Source files
------------

// File: rtl/source_config.sv
// Shared command-word definitions for the network_source input path:
// opcode encoding, word width and arbiter state type.
package source_config;

  localparam int SRC_WIDTH = 32;
  localparam int OPC_WIDTH = 3;
  localparam int NUM_OPS   = 5;

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_NOP      = 3'd0,
    OPC_SPK      = 3'd1,
    OPC_SPK_PRDC = 3'd2,
    OPC_RUN      = 3'd3,
    OPC_CLR      = 3'd4
  } opcode_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Opcodes that open a spike transaction.
  function automatic logic is_spike(input logic [OPC_WIDTH-1:0] opc);
    return (opc == OPC_SPK) || (opc == OPC_SPK_PRDC);
  endfunction

  // Opcodes that close a spike transaction.
  function automatic logic is_term(input logic [OPC_WIDTH-1:0] opc);
    return (opc == OPC_RUN) || (opc == OPC_CLR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one search: returns the first set bit of req
// starting at ptr and wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Round-robin merge of NUM_REQ host command streams into one registered src
// stream, keeping SPK/SPK_PRDC ... RUN/CLR transactions atomic per requester.
module dispatch_arbiter
  import source_config::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int SRC_W        = SRC_WIDTH,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW          = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [SRC_W-1:0]    req_data [0:NUM_REQ-1],
  output logic                src_valid,
  input  logic                src_ready,
  output logic [SRC_W-1:0]    src,
  output logic [IW-1:0]       owner,
  output logic                locked,
  output logic                lock_abort
);

  localparam logic [CW-1:0] TO_VAL = CW'(LOCK_TIMEOUT);

  arb_state_t           state_r, state_s;
  logic [IW-1:0]        owner_r, owner_s;
  logic [IW-1:0]        rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [IW-1:0]        pick_idx_s, grant_s;
  logic                 pick_any_s, load_en_s, accept_s, abort_s;
  logic [OPC_WIDTH-1:0] opc_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return i + 1'b1;
    end
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign load_en_s = !src_valid || src_ready;
  assign grant_s   = (state_r == ARB_LOCKED) ? owner_r : pick_idx_s;
  assign accept_s  = load_en_s &&
                     ((state_r == ARB_LOCKED) ? req_valid[owner_r] : pick_any_s);
  assign opc_s     = req_data[grant_s][SRC_W-1 -: OPC_WIDTH];
  assign owner     = owner_r;
  assign locked    = (state_r == ARB_LOCKED);

  // One-hot ready towards the granted requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept_s && (grant_s == IW'(i));
    end
  end

  // Lock FSM, round-robin pointer and idle-timeout counter next state.
  always_comb begin
    state_s  = state_r;
    owner_s  = owner_r;
    rr_ptr_s = rr_ptr_r;
    cnt_s    = cnt_r;
    abort_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        cnt_s = '0;
        if (accept_s) begin
          owner_s = grant_s;
          if (is_spike(opc_s)) begin
            state_s = ARB_LOCKED;
          end else begin
            rr_ptr_s = next_idx(grant_s);
          end
        end else begin
          owner_s = owner_r;
        end
      end
      ARB_LOCKED: begin
        if (accept_s) begin
          cnt_s = '0;
          if (is_term(opc_s)) begin
            state_s  = ARB_IDLE;
            rr_ptr_s = next_idx(owner_r);
          end else begin
            state_s = ARB_LOCKED;
          end
        end else if ((LOCK_TIMEOUT > 0) && !req_valid[owner_r]) begin
          // A stalled owner with valid held high never counts as idle.
          if (cnt_r != TO_VAL) begin
            cnt_s = cnt_r + 1'b1;
          end else begin
            cnt_s = cnt_r;
          end
          if (cnt_s == TO_VAL) begin
            state_s  = ARB_IDLE;
            rr_ptr_s = next_idx(owner_r);
            abort_s  = 1'b1;
          end else begin
            state_s = ARB_LOCKED;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r    <= ARB_IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      lock_abort <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      cnt_r      <= cnt_s;
      lock_abort <= abort_s;
    end
  end

  // Single output register; a new word may replace a consumed one with no bubble.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      src       <= '0;
      src_valid <= 1'b0;
    end else if (accept_s) begin
      src       <= req_data[grant_s];
      src_valid <= 1'b1;
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end else begin
      src_valid <= src_valid;
    end
  end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Randomized scoreboard bench for dispatch_arbiter: a transaction-level model
// predicts grants, lock state and the forwarded word order.
module tb_dispatch_arbiter;
  import source_config::*;

  localparam int N  = 2;
  localparam int W  = SRC_WIDTH;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           arstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   req_data [0:N-1];
  logic           src_valid;
  logic           src_ready = 1'b0;
  logic [W-1:0]   src;
  logic [0:0]     owner;
  logic           locked;
  logic           lock_abort;

  dispatch_arbiter #(.NUM_REQ(N), .SRC_W(W), .LOCK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src        (src),
    .owner      (owner),
    .locked     (locked),
    .lock_abort (lock_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int aborts_seen = 0;

  // Reference model state
  bit           m_locked, m_sv, m_abort;
  int           m_owner, m_ptr, m_idle;
  logic [W-1:0] exp_q [$];
  logic [N-1:0] acc_m = '0;
  int           g;
  bit           have, acc;
  logic [N-1:0] exp_ready;
  logic [2:0]   opc;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: check registered outputs, predict this cycle's grant, then advance.
  always @(negedge clk) begin
    if (!arstn) begin
      m_locked = 1'b0; m_sv = 1'b0; m_abort = 1'b0;
      m_owner = 0; m_ptr = 0; m_idle = 0;
      exp_q.delete();
      acc_m = '0;
    end else begin
      check("src_valid", W'(src_valid), W'(m_sv));
      check("locked", W'(locked), W'(m_locked));
      check("owner", W'(owner), W'(m_owner));
      check("lock_abort", W'(lock_abort), W'(m_abort));
      have = 1'b0;
      g = 0;
      if (m_locked) begin
        g = m_owner;
        have = req_valid[g];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!have && req_valid[(m_ptr + k) % N]) begin
            g = (m_ptr + k) % N;
            have = 1'b1;
          end
        end
      end
      acc = have && (!m_sv || src_ready);
      exp_ready = acc ? N'(1 << g) : '0;
      check("req_ready", W'(req_ready), W'(exp_ready));
      acc_m = exp_ready;
      m_abort = 1'b0;
      if (acc) begin
        exp_q.push_back(req_data[g]);
        opc = req_data[g][W-1 -: 3];
        m_idle = 0;
        if (!m_locked) begin
          m_owner = g;
          if (opc == OPC_SPK || opc == OPC_SPK_PRDC) m_locked = 1'b1;
          else m_ptr = (g + 1) % N;
        end else if (opc == OPC_RUN || opc == OPC_CLR) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % N;
        end
      end else if (m_locked && !req_valid[m_owner]) begin
        m_idle++;
        if (m_idle == TO) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % N;
          m_abort = 1'b1;
          m_idle = 0;
          aborts_seen++;
        end
      end
      m_sv = acc ? 1'b1 : (src_ready ? 1'b0 : m_sv);
    end
  end

  // Monitor: every consumed src word must be the oldest expected word.
  logic [W-1:0] prev_src;
  bit           prev_stall = 1'b0;
  logic [W-1:0] exp_word;
  always @(negedge clk) begin
    if (!arstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && src_valid) check("src_stable", src, prev_src);
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL src_unexpected: got %h expected none at %0t", src, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("src", src, exp_word);
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_src = src;
    end
  end

  function automatic logic [W-1:0] gen_word(input int mode);
    logic [W-1:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(99);
    if (mode == 0)    w[W-1 -: 3] = OPC_NOP;
    else if (r < 30)  w[W-1 -: 3] = OPC_SPK;
    else if (r < 40)  w[W-1 -: 3] = OPC_SPK_PRDC;
    else if (r < 60)  w[W-1 -: 3] = OPC_RUN;
    else if (r < 70)  w[W-1 -: 3] = OPC_CLR;
    else if (r < 85)  w[W-1 -: 3] = OPC_NOP;
    else              w[W-1 -: 3] = 3'($urandom_range(7, 5));
    return w;
  endfunction

  task automatic run(input int cycles, input int pv, input int pr, input int mode);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !acc_m[i])) begin
          req_valid[i] = ($urandom_range(99) < pv);
          req_data[i] = gen_word(mode);
        end
      end
      src_ready = ($urandom_range(99) < pr);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_src_valid", W'(src_valid), '0);
    check("rst_src", src, '0);
    check("rst_owner", W'(owner), '0);
    check("rst_locked", W'(locked), '0);
    check("rst_lock_abort", W'(lock_abort), '0);
    check("rst_req_ready", W'(req_ready), '0);
  endtask

  bit got_lock;

  initial begin
    for (int i = 0; i < N; i++) req_data[i] = '0;
    #12;
    check_reset_outputs();
    @(posedge clk); #1 arstn = 1'b1;

    run(40, 100, 100, 0);
    run(600, 70, 70, 1);
    run(600, 15, 90, 1);
    run(400, 90, 30, 1);
    run(10, 0, 100, 1);
    checks++;
    if (aborts_seen == 0) begin
      errors++;
      $display("FAIL timeout_coverage: got 0 lock aborts expected at least 1");
    end

    // Lock r0 with a stalled output, then reset mid-transaction.
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_data[0] = gen_word(0);
    req_data[0][W-1 -: 3] = OPC_SPK;
    src_ready = 1'b0;
    got_lock = 1'b0;
    for (int c = 0; c < 20 && !got_lock; c++) begin
      @(posedge clk); #1;
      got_lock = m_locked && m_sv;
    end
    checks++;
    if (!got_lock) begin
      errors++;
      $display("FAIL lock_before_reset: got no lock expected lock within 20 cycles");
    end
    arstn = 1'b0;
    req_valid = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    run(200, 60, 70, 1);
    run(20, 0, 100, 1);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
